inst_memory_hierarchy: RTL and testbench



---
 rtl/inst_memory_hierarchy.sv | 124 ++++++++++++
 tb/tb_inst_memory_hierarchy.sv | 139 +++++++++++++
 2 files changed

// File: rtl/inst_memory_hierarchy.sv
// Instruction memory hierarchy: direct-mapped instruction cache backed by an
// internal 256 x 16 ROM, with a single outstanding fetch request.
module inst_memory_hierarchy #(
    parameter int MEM_WAIT   = 0,
    parameter int NUM_LINES  = 8,
    parameter int LINE_WORDS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        read_enable,
    input  logic [7:0]  address,
    output logic        rd_ready,
    output logic [15:0] inst
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = 8 - OFF_W - IDX_W;
    localparam int WAIT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t               state;
    logic [7:0]           addr_q;
    logic [OFF_W-1:0]     word_cnt;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [15:0]          data_mem [NUM_LINES*LINE_WORDS];

    logic [TAG_W-1:0]     req_tag;
    logic [IDX_W-1:0]     req_idx;
    logic [OFF_W-1:0]     req_off;
    logic [TAG_W-1:0]     lat_tag;
    logic [IDX_W-1:0]     lat_idx;
    logic [7:0]           fill_addr;
    logic                 hit;
    logic                 word_done;
    logic                 last_word;

    // Main-memory contents are a fixed function of the word address.
    function automatic logic [15:0] rom_word(input logic [7:0] a);
        return {a, ~a};
    endfunction

    assign req_tag   = address[7 -: TAG_W];
    assign req_idx   = address[OFF_W +: IDX_W];
    assign req_off   = address[OFF_W-1:0];
    assign lat_tag   = addr_q[7 -: TAG_W];
    assign lat_idx   = addr_q[OFF_W +: IDX_W];
    assign fill_addr = {addr_q[7:OFF_W], word_cnt};

    assign hit       = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign word_done = (state == REFILL) && (wait_cnt == WAIT_W'(MEM_WAIT));
    assign last_word = (word_cnt == OFF_W'(LINE_WORDS - 1));

    // Line data and tags carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clock) begin
        if (word_done) begin
            data_mem[{lat_idx, word_cnt}] <= rom_word(fill_addr);
            if (last_word) begin
                tag_mem[lat_idx] <= lat_tag;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            valid    <= '0;
            rd_ready <= 1'b0;
            inst     <= 16'h0000;
            addr_q   <= 8'h00;
            word_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (read_enable) begin
                        addr_q <= address;
                        if (hit) begin
                            inst     <= data_mem[{req_idx, req_off}];
                            rd_ready <= 1'b1;
                            state    <= DONE;
                        end else begin
                            // The line is being overwritten, so it must not hit until complete.
                            valid[req_idx] <= 1'b0;
                            word_cnt       <= '0;
                            wait_cnt       <= '0;
                            state          <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (word_done) begin
                        wait_cnt <= '0;
                        if (last_word) begin
                            valid[lat_idx] <= 1'b1;
                            inst           <= rom_word(addr_q);
                            rd_ready       <= 1'b1;
                            state          <= DONE;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (!read_enable) begin
                        rd_ready <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_memory_hierarchy.sv
// Bench for inst_memory_hierarchy: a default build and a MEM_WAIT=2 build,
// checked against a line-level cache model with latency from the miss formula.
module tb_inst_memory_hierarchy;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  re    = 2'b00;
    logic [7:0]  addr  [2];
    logic [1:0]  rdy;
    logic [15:0] inst_o [2];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: per build, which tag occupies each line.
    bit mval [2][8];
    int mtag [2][8];
    int mwait [2] = '{0, 2};

    always #5 clock = ~clock;

    inst_memory_hierarchy #(.MEM_WAIT(0), .NUM_LINES(8), .LINE_WORDS(4)) dut0 (
        .clock(clock), .reset(reset), .read_enable(re[0]), .address(addr[0]),
        .rd_ready(rdy[0]), .inst(inst_o[0])
    );

    inst_memory_hierarchy #(.MEM_WAIT(2), .NUM_LINES(8), .LINE_WORDS(4)) dut1 (
        .clock(clock), .reset(reset), .read_enable(re[1]), .address(addr[1]),
        .rd_ready(rdy[1]), .inst(inst_o[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_word(input int a);
        logic [7:0] b;
        b = a[7:0];
        return {b, ~b};
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++)
            for (int l = 0; l < 8; l++)
                mval[d][l] = 1'b0;
    endtask

    // One fetch: present at a negedge, count edges to rd_ready, hold, release.
    task automatic fetch(input int d, input int a, input int hold);
        int idx, tg, lat, cyc;
        logic [15:0] w;
        idx = (a / 4) % 8;
        tg  = a / 32;
        w   = exp_word(a);
        lat = (mval[d][idx] && mtag[d][idx] == tg) ? 1 : 1 + 4 * (mwait[d] + 1);
        mval[d][idx] = 1'b1;
        mtag[d][idx] = tg;
        addr[d] = 8'(a);
        re[d]   = 1'b1;
        cyc     = 0;
        while (1) begin
            @(posedge clock);
            cyc++;
            #1 addr[d] = 8'($urandom);
            @(negedge clock);
            if (rdy[d] === 1'b1) break;
            if (cyc > 40) begin
                check($sformatf("timeout d%0d a%0h", d, a), 32'(cyc), 32'(lat));
                re[d] = 1'b0;
                return;
            end
        end
        check($sformatf("latency d%0d a%0h", d, a), 32'(cyc), 32'(lat));
        check($sformatf("inst d%0d a%0h", d, a), 32'(inst_o[d]), 32'(w));
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            check($sformatf("hold_rdy d%0d", d), 32'(rdy[d]), 32'd1);
            check($sformatf("hold_inst d%0d", d), 32'(inst_o[d]), 32'(w));
        end
        re[d] = 1'b0;
        @(negedge clock);
        check($sformatf("drop_rdy d%0d", d), 32'(rdy[d]), 32'd0);
        check($sformatf("drop_inst d%0d", d), 32'(inst_o[d]), 32'(w));
    endtask

    initial begin
        addr[0] = 8'h00;
        addr[1] = 8'h00;
        model_clear();
        repeat (2) @(negedge clock);
        check("reset_rdy0", 32'(rdy[0]), 32'd0);
        check("reset_inst0", 32'(inst_o[0]), 32'd0);
        check("reset_rdy1", 32'(rdy[1]), 32'd0);
        check("reset_inst1", 32'(inst_o[1]), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        fetch(0, 8'h02, 2);
        fetch(0, 8'h01, 1);
        fetch(0, 8'h05, 0);
        fetch(0, 8'h03, 1);
        fetch(0, 8'h22, 0);
        fetch(0, 8'h02, 0);
        fetch(1, 8'h00, 1);
        fetch(1, 8'h03, 0);

        // Reset in the middle of a refill.
        addr[0] = 8'h40;
        re[0]   = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        re[0] = 1'b0;
        #1;
        check("midreset_rdy", 32'(rdy[0]), 32'd0);
        check("midreset_inst", 32'(inst_o[0]), 32'd0);
        model_clear();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        fetch(0, 8'h40, 0);
        fetch(0, 8'h41, 0);
        fetch(1, 8'h00, 0);

        for (int i = 0; i < 60; i++) begin
            int a;
            a = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 255);
            fetch(i % 2, a, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
